// File: rtl/i2c_xfer_ctrl_pkg.sv
// Shared definitions for the I2C transfer sequencer: core command codes,
// sequencer states and the state decode helpers used for registered outputs.
package i2c_xfer_ctrl_pkg;

    localparam int I2C_XFER_LEN_WIDTH = 8;

    localparam logic [1:0] I2C_CMD_START = 2'd0;
    localparam logic [1:0] I2C_CMD_STOP  = 2'd1;
    localparam logic [1:0] I2C_CMD_WRITE = 2'd2;
    localparam logic [1:0] I2C_CMD_READ  = 2'd3;

    typedef enum logic [2:0] {
        XFER_IDLE    = 3'd0,
        XFER_START   = 3'd1,
        XFER_ADDR    = 3'd2,
        XFER_WAIT_TX = 3'd3,
        XFER_WDATA   = 3'd4,
        XFER_RDATA   = 3'd5,
        XFER_PUSH_RX = 3'd6,
        XFER_STOP    = 3'd7
    } i2c_xfer_state_e;

    function automatic logic state_has_cmd(input i2c_xfer_state_e s);
        case (s)
            XFER_START, XFER_ADDR, XFER_WDATA, XFER_RDATA, XFER_STOP: return 1'b1;
            default:                                                  return 1'b0;
        endcase
    endfunction

    // Non-command states decode to 0 so an idle bus shows an all-zero command.
    function automatic logic [1:0] state_cmd(input i2c_xfer_state_e s);
        case (s)
            XFER_ADDR, XFER_WDATA: return I2C_CMD_WRITE;
            XFER_RDATA:            return I2C_CMD_READ;
            XFER_STOP:             return I2C_CMD_STOP;
            default:               return I2C_CMD_START;
        endcase
    endfunction

endpackage

// File: rtl/i2c_xfer_ctrl_if.sv
// Bundle of the register-layer, FIFO and byte-core signals around the sequencer.
// The master modport is the sequencer itself; slave is its environment.
interface i2c_xfer_ctrl_if
    import i2c_xfer_ctrl_pkg::*;
#(
    parameter int LEN_WIDTH = I2C_XFER_LEN_WIDTH
);
    logic                 start_i;
    logic                 abort_i;
    logic [6:0]           addr_i;
    logic                 rw_i;
    logic [LEN_WIDTH-1:0] len_i;
    logic                 busy_o;
    logic                 done_o;
    logic                 nack_o;
    logic [7:0]           tx_data_i;
    logic                 tx_valid_i;
    logic                 tx_ready_o;
    logic [7:0]           rx_data_o;
    logic                 rx_valid_o;
    logic                 rx_ready_i;
    logic                 cmd_valid_o;
    logic [1:0]           cmd_o;
    logic [7:0]           cmd_data_o;
    logic                 cmd_ack_o;
    logic                 core_done_i;
    logic [7:0]           core_rxd_i;
    logic                 core_rxack_i;

    modport master (
        input  start_i, abort_i, addr_i, rw_i, len_i,
        input  tx_data_i, tx_valid_i, rx_ready_i,
        input  core_done_i, core_rxd_i, core_rxack_i,
        output busy_o, done_o, nack_o, tx_ready_o, rx_data_o, rx_valid_o,
        output cmd_valid_o, cmd_o, cmd_data_o, cmd_ack_o
    );

    modport slave (
        output start_i, abort_i, addr_i, rw_i, len_i,
        output tx_data_i, tx_valid_i, rx_ready_i,
        output core_done_i, core_rxd_i, core_rxack_i,
        input  busy_o, done_o, nack_o, tx_ready_o, rx_data_o, rx_valid_o,
        input  cmd_valid_o, cmd_o, cmd_data_o, cmd_ack_o
    );
endinterface

// File: rtl/i2c_xfer_ctrl.sv
// I2C transfer sequencer: turns one descriptor into START, address, data bytes
// and STOP commands for the byte core, moving data between the FIFOs and core.
module i2c_xfer_ctrl
    import i2c_xfer_ctrl_pkg::*;
#(
    parameter int LEN_WIDTH = I2C_XFER_LEN_WIDTH
)
(
    input  logic            clk_i,
    input  logic            rst_n_i,
    i2c_xfer_ctrl_if.master bus
);

    i2c_xfer_state_e      state_r, state_nxt;
    logic [LEN_WIDTH-1:0] cnt_r, cnt_nxt, cnt_dec_s;
    logic [6:0]           addr_r, addr_nxt;
    logic                 rw_r, rw_nxt;
    logic                 nack_flag_r, nack_flag_nxt;
    logic                 abort_flag_r, abort_flag_nxt;
    logic                 busy_r, busy_nxt;
    logic                 done_r, done_nxt;
    logic                 nack_r, nack_nxt;
    logic                 cmd_valid_r;
    logic [1:0]           cmd_r;
    logic [7:0]           cmd_data_r, cmd_data_nxt;
    logic                 cmd_ack_r;
    logic [7:0]           rx_data_r, rx_data_nxt;
    logic                 rx_valid_r;
    logic                 core_done_s;
    logic                 abort_any_s;
    logic                 cnt_zero_s;
    logic                 cnt_dec_zero_s;

    // Core completions only count while a command is actually being presented.
    assign core_done_s    = bus.core_done_i & cmd_valid_r;
    assign abort_any_s    = abort_flag_r | bus.abort_i;
    assign cnt_zero_s     = (cnt_r == {LEN_WIDTH{1'b0}});
    assign cnt_dec_s      = cnt_zero_s ? cnt_r : (cnt_r - LEN_WIDTH'(1));
    assign cnt_dec_zero_s = (cnt_dec_s == {LEN_WIDTH{1'b0}});

    assign bus.tx_ready_o  = (state_r == XFER_WAIT_TX) & bus.tx_valid_i & ~bus.abort_i;
    assign bus.busy_o      = busy_r;
    assign bus.done_o      = done_r;
    assign bus.nack_o      = nack_r;
    assign bus.cmd_valid_o = cmd_valid_r;
    assign bus.cmd_o       = cmd_r;
    assign bus.cmd_data_o  = cmd_data_r;
    assign bus.cmd_ack_o   = cmd_ack_r;
    assign bus.rx_data_o   = rx_data_r;
    assign bus.rx_valid_o  = rx_valid_r;

    // Next-state, counter, flag and data-latch decisions for the sequencer.
    always_comb begin
        state_nxt      = state_r;
        cnt_nxt        = cnt_r;
        addr_nxt       = addr_r;
        rw_nxt         = rw_r;
        nack_flag_nxt  = nack_flag_r;
        abort_flag_nxt = abort_flag_r;
        busy_nxt       = busy_r;
        done_nxt       = 1'b0;
        nack_nxt       = 1'b0;
        cmd_data_nxt   = cmd_data_r;
        rx_data_nxt    = rx_data_r;
        case (state_r)
            XFER_IDLE: begin
                // The done cycle still belongs to the finished transfer.
                if (bus.start_i && !done_r) begin
                    addr_nxt       = bus.addr_i;
                    rw_nxt         = bus.rw_i;
                    cnt_nxt        = bus.len_i;
                    nack_flag_nxt  = 1'b0;
                    abort_flag_nxt = 1'b0;
                    busy_nxt       = 1'b1;
                    state_nxt      = XFER_START;
                end else begin
                    state_nxt = XFER_IDLE;
                end
            end
            XFER_START: begin
                abort_flag_nxt = abort_any_s;
                if (core_done_s) begin
                    cmd_data_nxt = {addr_r, rw_r};
                    state_nxt    = XFER_ADDR;
                end else begin
                    state_nxt = XFER_START;
                end
            end
            XFER_ADDR: begin
                abort_flag_nxt = abort_any_s;
                if (core_done_s) begin
                    if (bus.core_rxack_i) begin
                        nack_flag_nxt = 1'b1;
                        state_nxt     = XFER_STOP;
                    end else if (cnt_zero_s || abort_any_s) begin
                        state_nxt = XFER_STOP;
                    end else if (rw_r) begin
                        state_nxt = XFER_RDATA;
                    end else begin
                        state_nxt = XFER_WAIT_TX;
                    end
                end else begin
                    state_nxt = XFER_ADDR;
                end
            end
            XFER_WAIT_TX: begin
                if (bus.abort_i) begin
                    state_nxt = XFER_STOP;
                end else if (bus.tx_valid_i) begin
                    cmd_data_nxt = bus.tx_data_i;
                    state_nxt    = XFER_WDATA;
                end else begin
                    state_nxt = XFER_WAIT_TX;
                end
            end
            XFER_WDATA: begin
                abort_flag_nxt = abort_any_s;
                if (core_done_s) begin
                    cnt_nxt = cnt_dec_s;
                    if (bus.core_rxack_i) begin
                        nack_flag_nxt = 1'b1;
                        state_nxt     = XFER_STOP;
                    end else if (cnt_dec_zero_s || abort_any_s) begin
                        state_nxt = XFER_STOP;
                    end else begin
                        state_nxt = XFER_WAIT_TX;
                    end
                end else begin
                    state_nxt = XFER_WDATA;
                end
            end
            XFER_RDATA: begin
                abort_flag_nxt = abort_any_s;
                if (core_done_s) begin
                    rx_data_nxt = bus.core_rxd_i;
                    state_nxt   = XFER_PUSH_RX;
                end else begin
                    state_nxt = XFER_RDATA;
                end
            end
            XFER_PUSH_RX: begin
                if (bus.abort_i) begin
                    state_nxt = XFER_STOP;
                end else if (bus.rx_ready_i) begin
                    cnt_nxt = cnt_dec_s;
                    if (cnt_dec_zero_s || abort_flag_r) begin
                        state_nxt = XFER_STOP;
                    end else begin
                        state_nxt = XFER_RDATA;
                    end
                end else begin
                    state_nxt = XFER_PUSH_RX;
                end
            end
            XFER_STOP: begin
                if (core_done_s) begin
                    done_nxt  = 1'b1;
                    nack_nxt  = nack_flag_r;
                    busy_nxt  = 1'b0;
                    state_nxt = XFER_IDLE;
                end else begin
                    state_nxt = XFER_STOP;
                end
            end
            default: begin
                busy_nxt  = 1'b0;
                state_nxt = XFER_IDLE;
            end
        endcase
    end

    // State and output registers; command outputs decode the upcoming state.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_r      <= XFER_IDLE;
            cnt_r        <= {LEN_WIDTH{1'b0}};
            addr_r       <= 7'd0;
            rw_r         <= 1'b0;
            nack_flag_r  <= 1'b0;
            abort_flag_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            nack_r       <= 1'b0;
            cmd_valid_r  <= 1'b0;
            cmd_r        <= 2'd0;
            cmd_data_r   <= 8'd0;
            cmd_ack_r    <= 1'b0;
            rx_data_r    <= 8'd0;
            rx_valid_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt;
            cnt_r        <= cnt_nxt;
            addr_r       <= addr_nxt;
            rw_r         <= rw_nxt;
            nack_flag_r  <= nack_flag_nxt;
            abort_flag_r <= abort_flag_nxt;
            busy_r       <= busy_nxt;
            done_r       <= done_nxt;
            nack_r       <= nack_nxt;
            cmd_valid_r  <= state_has_cmd(state_nxt);
            cmd_r        <= state_cmd(state_nxt);
            cmd_data_r   <= cmd_data_nxt;
            cmd_ack_r    <= (state_nxt == XFER_RDATA) && (cnt_nxt == LEN_WIDTH'(1));
            rx_data_r    <= rx_data_nxt;
            rx_valid_r   <= (state_nxt == XFER_PUSH_RX);
        end
    end

endmodule

// File: tb/tb_i2c_xfer_ctrl.sv
// Directed and randomized transfers against a command-list reference model;
// the bench plays the byte core, the TX FIFO and the RX FIFO.
module tb_i2c_xfer_ctrl;
    import i2c_xfer_ctrl_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2c_xfer_ctrl_if #(.LEN_WIDTH(8)) bus ();
    i2c_xfer_ctrl #(.LEN_WIDTH(8)) dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus.master));

    int vectors     = 0;
    int miscompares = 0;

    logic [9:0] exp_cmds[$];
    logic [9:0] obs_cmds[$];
    logic [7:0] exp_rx[$];
    logic [7:0] obs_rx[$];
    logic [7:0] tx_bytes[$];
    logic [7:0] rx_bytes[$];
    int         exp_pops;
    int         obs_pops;
    logic       exp_nack;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, bus.busy_o, 0);
        check({tag, "_done"}, bus.done_o, 0);
        check({tag, "_nack"}, bus.nack_o, 0);
        check({tag, "_tx_ready"}, bus.tx_ready_o, 0);
        check({tag, "_rx_valid"}, bus.rx_valid_o, 0);
        check({tag, "_rx_data"}, bus.rx_data_o, 0);
        check({tag, "_cmd_valid"}, bus.cmd_valid_o, 0);
        check({tag, "_cmd"}, bus.cmd_o, 0);
        check({tag, "_cmd_data"}, bus.cmd_data_o, 0);
        check({tag, "_cmd_ack"}, bus.cmd_ack_o, 0);
    endtask

    // Expected command list: build the full uninterrupted transfer, then cut it
    // at the point an abort or NACK ends it and append STOP.
    task automatic build_model(input logic [6:0] a, input logic rw, input int len,
                               input int nack_at, input int abort_cmd,
                               input int abort_rx, input bit stall);
        logic [9:0] full[$];
        int keep;
        exp_cmds.delete(); exp_rx.delete(); exp_pops = 0;
        full.push_back({I2C_CMD_START, 8'h00});
        full.push_back({I2C_CMD_WRITE, a, rw});
        if (nack_at != 0) begin
            for (int j = 1; j <= len; j++) begin
                if (rw) full.push_back({I2C_CMD_READ, 7'd0, (j == len)});
                else    full.push_back({I2C_CMD_WRITE, tx_bytes[j-1]});
                if (!rw && nack_at == j) break;
            end
        end
        keep = full.size();
        if (stall) keep = 2;
        if (abort_cmd >= 0) keep = (abort_cmd == 0) ? 2 : abort_cmd + 1;
        if (abort_rx > 0) keep = abort_rx + 2;
        if (keep > full.size()) keep = full.size();
        for (int i = 0; i < keep; i++) begin
            exp_cmds.push_back(full[i]);
            if (i >= 2 && rw && !(abort_rx > 0 && i == abort_rx + 1)) exp_rx.push_back(rx_bytes[i-2]);
            if (i >= 2 && !rw) exp_pops++;
        end
        exp_cmds.push_back({I2C_CMD_STOP, 8'h00});
        exp_nack = (nack_at >= 0) && (nack_at + 1 < keep);
    endtask

    task automatic run_xfer(input logic [6:0] a, input logic rw, input int len,
                            input int nack_at, input int abort_cmd, input int abort_rx,
                            input bit stall, input bit coin, input bit rst_mid);
        int ctr = $urandom_range(0, 3);
        int wr_cnt = 0, rd_cnt = 0, tx_idx = 0, idle_run = 0, stop_cyc = -10;
        bit finished = 0, aborted = 0, rx_hold = 0, did_rst = 0;
        logic [7:0] held = 8'h00;
        build_model(a, rw, len, nack_at, abort_cmd, abort_rx, stall);
        obs_cmds.delete(); obs_rx.delete(); obs_pops = 0;
        @(negedge clk);
        bus.addr_i = a; bus.rw_i = rw; bus.len_i = 8'(len); bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0; bus.addr_i = 7'($urandom); bus.rw_i = 1'($urandom);
        bus.len_i = 8'($urandom);
        check("start_busy", bus.busy_o, 1);
        check("start_cmd_valid", bus.cmd_valid_o, 1);
        check("start_cmd", bus.cmd_o, I2C_CMD_START);
        for (int cyc = 1; cyc <= 3000 && !finished; cyc++) begin
            if (rx_hold) begin
                check("rx_valid_held", bus.rx_valid_o, 1);
                check("rx_data_held", bus.rx_data_o, held);
            end
            bus.core_done_i = 1'b0; bus.abort_i = 1'b0;
            bus.rx_ready_i = ($urandom_range(0, 3) != 0);
            if (bus.done_o) begin
                check("done_latency", cyc, stop_cyc + 1);
                check("done_nack", bus.nack_o, exp_nack);
                check("done_busy_low", bus.busy_o, 0);
                finished = 1;
                bus.start_i = coin;
            end else begin
                idle_run = (bus.busy_o && !bus.cmd_valid_o) ? idle_run + 1 : 0;
                if (rst_mid && bus.cmd_valid_o && bus.cmd_o == I2C_CMD_WRITE && obs_cmds.size() >= 2) begin
                    rst_n = 1'b0; did_rst = 1; finished = 1;
                end else if (stall && idle_run == 20 && !aborted) begin
                    check("stall_no_cmd", obs_cmds.size(), 2);
                    bus.abort_i = 1'b1; aborted = 1;
                end else if (abort_rx > 0 && bus.rx_valid_o && rd_cnt == abort_rx && !aborted) begin
                    bus.rx_ready_i = 1'b0; bus.abort_i = 1'b1; aborted = 1;
                end else if (abort_cmd >= 0 && bus.cmd_valid_o && obs_cmds.size() == abort_cmd
                             && bus.cmd_o != I2C_CMD_STOP && !aborted) begin
                    bus.abort_i = 1'b1; aborted = 1;
                end else if (bus.cmd_valid_o) begin
                    if (ctr == 0) begin
                        bus.core_done_i = 1'b1; ctr = $urandom_range(0, 3);
                        bus.core_rxack_i = 1'b0; bus.core_rxd_i = 8'($urandom);
                        if (bus.cmd_o == I2C_CMD_WRITE) begin
                            bus.core_rxack_i = (wr_cnt == nack_at); wr_cnt++;
                        end else if (bus.cmd_o == I2C_CMD_READ) begin
                            bus.core_rxd_i = rx_bytes[rd_cnt]; rd_cnt++;
                        end
                    end else begin
                        ctr--;
                    end
                end else begin
                    bus.core_done_i = ($urandom_range(0, 5) == 0);
                    bus.core_rxack_i = 1'($urandom); bus.core_rxd_i = 8'($urandom);
                end
            end
            bus.tx_valid_i = !stall && (tx_idx < tx_bytes.size()) && ($urandom_range(0, 2) != 0);
            bus.tx_data_i  = bus.tx_valid_i ? tx_bytes[tx_idx] : 8'($urandom);
            #1;
            if (bus.core_done_i && bus.cmd_valid_o) begin
                if (bus.cmd_o == I2C_CMD_READ) obs_cmds.push_back({bus.cmd_o, 7'd0, bus.cmd_ack_o});
                else if (bus.cmd_o == I2C_CMD_WRITE) obs_cmds.push_back({bus.cmd_o, bus.cmd_data_o});
                else obs_cmds.push_back({bus.cmd_o, 8'h00});
                if (bus.cmd_o == I2C_CMD_STOP) stop_cyc = cyc;
            end
            if (bus.tx_valid_i && bus.tx_ready_o) begin obs_pops++; tx_idx++; end
            if (bus.rx_valid_o && bus.rx_ready_i) obs_rx.push_back(bus.rx_data_o);
            rx_hold = bus.rx_valid_o && !bus.rx_ready_i && !bus.abort_i && !did_rst;
            held = bus.rx_data_o;
            @(negedge clk);
        end
        check("transfer_finished", finished, 1);
        bus.start_i = 1'b0; bus.core_done_i = 1'b0; bus.abort_i = 1'b0;
        if (did_rst) begin
            bus.tx_valid_i = 1'b1;
            #1;
            check_all_zero("mid_reset");
            rst_n = 1'b1;
        end else begin
            check("done_one_cycle", bus.done_o, 0);
            check("start_during_done_ignored", bus.busy_o, 0);
            check("cmd_count", obs_cmds.size(), exp_cmds.size());
            for (int i = 0; i < exp_cmds.size() && i < obs_cmds.size(); i++)
                check($sformatf("cmd%0d", i), obs_cmds[i], exp_cmds[i]);
            check("rx_count", obs_rx.size(), exp_rx.size());
            for (int i = 0; i < exp_rx.size() && i < obs_rx.size(); i++)
                check($sformatf("rx%0d", i), obs_rx[i], exp_rx[i]);
            check("tx_pops", obs_pops, exp_pops);
        end
        if (!finished) begin
            rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
        end
        bus.tx_valid_i = 1'b0;
    endtask

    task automatic fill(input int len);
        tx_bytes.delete(); rx_bytes.delete();
        for (int i = 0; i < len; i++) begin
            tx_bytes.push_back(8'($urandom)); rx_bytes.push_back(8'($urandom));
        end
    endtask

    initial begin
        bus.start_i = 1'b0; bus.abort_i = 1'b0; bus.addr_i = 7'd0; bus.rw_i = 1'b0;
        bus.len_i = 8'd0; bus.tx_data_i = 8'd0; bus.tx_valid_i = 1'b1; bus.rx_ready_i = 1'b0;
        bus.core_done_i = 1'b0; bus.core_rxd_i = 8'd0; bus.core_rxack_i = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        bus.tx_valid_i = 1'b0;

        tx_bytes = '{8'hA5, 8'h3C}; rx_bytes = '{8'h00, 8'h00};
        run_xfer(7'h50, 1'b0, 2, -1, -1, -1, 0, 0, 0);
        tx_bytes = '{8'h00, 8'h00, 8'h00}; rx_bytes = '{8'h11, 8'h22, 8'h33};
        run_xfer(7'h51, 1'b1, 3, -1, -1, -1, 0, 1, 0);
        fill(3);
        run_xfer(7'h2A, 1'b0, 3, 0, -1, -1, 0, 0, 0);
        fill(0);
        run_xfer(7'h3B, 1'b0, 0, -1, -1, -1, 0, 1, 0);
        fill(2);
        run_xfer(7'h44, 1'b0, 2, -1, -1, -1, 1, 0, 0);
        fill(4);
        run_xfer(7'h12, 1'b1, 4, -1, 3, -1, 0, 0, 0);
        fill(4);
        run_xfer(7'h13, 1'b1, 4, -1, -1, 2, 0, 0, 0);
        fill(3);
        run_xfer(7'h7F, 1'b0, 3, -1, 0, -1, 0, 0, 0);
        fill(3);
        run_xfer(7'h60, 1'b0, 3, 2, -1, -1, 0, 0, 0);
        fill(3);
        run_xfer(7'h61, 1'b0, 3, -1, -1, -1, 0, 0, 1);
        fill(2);
        run_xfer(7'h62, 1'b0, 2, -1, -1, -1, 0, 0, 0);

        for (int t = 0; t < 24; t++) begin
            logic rw;
            int len, nack_at, n_full, abort_cmd, abort_rx, mode;
            rw = 1'($urandom); len = $urandom_range(0, 6);
            if (rw) nack_at = ($urandom_range(0, 3) == 0) ? 0 : -1;
            else    nack_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
            if (nack_at == 0)     n_full = 2;
            else if (nack_at > 0) n_full = nack_at + 2;
            else                  n_full = len + 2;
            abort_cmd = -1; abort_rx = -1;
            mode = $urandom_range(0, 2);
            if (mode == 1) abort_cmd = $urandom_range(0, n_full - 1);
            if (mode == 2 && rw && len > 0 && nack_at != 0) abort_rx = $urandom_range(1, len);
            fill(len);
            run_xfer(7'($urandom), rw, len, nack_at, abort_cmd, abort_rx, 0, 1'($urandom), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
